// File: rtl/step_pulse_gen.sv
// Step-command consumer: pops period/direction words from the command FIFO and
// emits timed STEP pulses with DIR setup. Optional position counter: STEP_POS_CNT_EN.
module step_pulse_gen #(
    parameter int PULSE_W   = 4,
    parameter int DIR_SETUP = 2,
    parameter int MIN_LOW   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [15:0]        fifo_data,
    input  logic               fifo_empty,
    output logic               fifo_rd,
    output logic               step,
    output logic               dir,
    output logic               busy,
    output logic               underrun,
    input  logic               clr_underrun,
    output logic signed [15:0] pos
);

    localparam int          MIN_PE     = PULSE_W + MIN_LOW;
    localparam logic [15:0] HIGH_LAST  = 16'(PULSE_W - 1);
    localparam logic [15:0] SETUP_LAST = 16'(DIR_SETUP - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SETUP = 3'd3,
        HIGH  = 3'd4,
        LOW   = 3'd5
    } state_t;

    // Clamp the commanded period to the shortest legal one and return the low length.
    function automatic logic [15:0] clamp_low_len(input logic [14:0] period);
        logic [15:0] pe;
        pe = {1'b0, period};
        if (pe < 16'(MIN_PE))
            pe = 16'(MIN_PE);
        return pe - 16'(PULSE_W);
    endfunction

    state_t      state, state_nxt, cap_state;
    logic [15:0] cnt, cnt_nxt;
    logic [15:0] low_len;
    logic        pf, miss;
    logic        rd_req, set_ur, cap_en;
    logic        low_pre, low_last;
    logic [14:0] word_p;
    logic        word_dir;

    assign word_p   = fifo_data[14:0];
    assign word_dir = fifo_data[15];
    assign low_pre  = (state == LOW) && (cnt == low_len - 16'd2);
    assign low_last = (state == LOW) && (cnt == low_len - 16'd1);
    assign cap_en   = (state == LOAD) || (low_last && pf);
    assign busy     = (state != IDLE);
    assign fifo_rd  = rd_req & rst_n;

    always_comb begin
        if (word_p == '0)
            cap_state = IDLE;
        else if (word_dir != dir)
            cap_state = SETUP;
        else
            cap_state = HIGH;
    end

    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        set_ur    = 1'b0;
        case (state)
            IDLE: begin
                if (en && !fifo_empty) begin
                    rd_req    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: state_nxt = LOAD;
            LOAD:  state_nxt = cap_state;
            SETUP: begin
                if (cnt == SETUP_LAST)
                    state_nxt = HIGH;
            end
            HIGH: begin
                if (cnt == HIGH_LAST)
                    state_nxt = LOW;
            end
            LOW: begin
                // Prefetch one cycle early so the word is on fifo_data at the last low cycle.
                if (low_pre && en && !fifo_empty)
                    rd_req = 1'b1;
                if (low_last) begin
                    if (pf) begin
                        state_nxt = cap_state;
                    end else begin
                        state_nxt = IDLE;
                        set_ur    = miss;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if ((state_nxt != state) || (state == IDLE))
            cnt_nxt = '0;
        else
            cnt_nxt = cnt + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            step     <= 1'b0;
            dir      <= 1'b0;
            pf       <= 1'b0;
            miss     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            step  <= (state_nxt == HIGH);
            if (cap_en && (word_p != '0))
                dir <= word_dir;
            if (low_pre) begin
                pf   <= rd_req;
                miss <= en && fifo_empty;
            end else if (state != LOW) begin
                pf   <= 1'b0;
                miss <= 1'b0;
            end
            if (set_ur)
                underrun <= 1'b1;
            else if (clr_underrun)
                underrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en)
            low_len <= clamp_low_len(word_p);
    end

`ifdef STEP_POS_CNT_EN
    logic signed [15:0] pos_q;

    // Count on entry to HIGH; dir is already final there (SETUP precedes any change).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pos_q <= '0;
        else if ((state_nxt == HIGH) && (state != HIGH))
            pos_q <= dir ? (pos_q + 16'sd1) : (pos_q - 16'sd1);
    end

    assign pos = pos_q;
`else
    assign pos = '0;
`endif

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: FIFO model, edge monitor and a word-level timing model.
`timescale 1ns/1ps
module tb_step_pulse_gen;

    localparam int PW = 4;
    localparam int DS = 2;
    localparam int ML = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic clr_underrun = 1'b0;
    logic [15:0] fifo_data;
    logic fifo_empty, fifo_rd, step, dir, busy, underrun;
    logic signed [15:0] pos;

    step_pulse_gen #(.PULSE_W(PW), .DIR_SETUP(DS), .MIN_LOW(ML)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .step(step), .dir(dir),
        .busy(busy), .underrun(underrun), .clr_underrun(clr_underrun), .pos(pos)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO with registered output
    logic [15:0] mem [0:1023];
    int wr_ptr, rd_ptr, rd_cnt, rd_empty;
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_rd) begin
            rd_cnt <= rd_cnt + 1;
            if (wr_ptr == rd_ptr) begin
                rd_empty <= rd_empty + 1;
            end else begin
                fifo_data <= mem[rd_ptr[9:0]];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    // Output monitor
    int rise_t[$];
    bit rise_d[$];
    int width_bad, dir_hi_chg, last_fall, hi_len;
    logic step_prev, dir_prev, busy_prev;
    always @(negedge clk) begin
        if (!rst_n) begin
            step_prev <= 1'b0;
            dir_prev  <= 1'b0;
            busy_prev <= 1'b0;
            hi_len    <= 0;
        end else begin
            if (step && !step_prev) begin
                rise_t.push_back(cyc);
                rise_d.push_back(dir);
            end
            if (step)
                hi_len <= hi_len + 1;
            if (!step && step_prev) begin
                if (hi_len != PW)
                    width_bad <= width_bad + 1;
                hi_len <= 0;
            end
            if (step && (dir != dir_prev))
                dir_hi_chg <= dir_hi_chg + 1;
            if (!busy && busy_prev)
                last_fall <= cyc;
            step_prev <= step;
            dir_prev  <= dir;
            busy_prev <= busy;
        end
    end

    int n_cmp, n_bad;
    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic at_pos(input int c);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < c);
    endtask

    task automatic at_neg(input int c);
        do @(negedge clk); while (cyc < c);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr_ptr[9:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        en = 1'b0;
        clr_underrun = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Word-level model: rising-edge times from the period/direction rules
    logic [15:0] scn_w[$];
    int exp_rise[$];
    bit exp_dir[$];
    int exp_idle, exp_ur, exp_pos;

    function automatic void model(input int t0);
        int t, last_rise, last_pe, base, p;
        bit cur_dir, fresh;
        exp_rise.delete();
        exp_dir.delete();
        exp_ur = 0; exp_pos = 0;
        t = t0; cur_dir = 1'b0; fresh = 1'b1;
        last_rise = 0; last_pe = 0; exp_idle = t0;
        foreach (scn_w[i]) begin
            base = fresh ? t + 3 : last_rise + last_pe;
            p = int'(scn_w[i][14:0]);
            if (p == 0) begin
                t = base;
                exp_idle = base;
                fresh = 1'b1;
            end else begin
                if (scn_w[i][15] != cur_dir)
                    base += DS;
                cur_dir = scn_w[i][15];
                exp_rise.push_back(base);
                exp_dir.push_back(cur_dir);
                exp_pos += cur_dir ? 1 : -1;
                last_rise = base;
                last_pe = (p < PW + ML) ? PW + ML : p;
                fresh = 1'b0;
            end
        end
        if (!fresh) begin
            exp_ur = 1;
            exp_idle = last_rise + last_pe;
        end
    endfunction

    task automatic run_scn(input string nm);
        int t0, rb, wb, db, rdb, reb, nobs;
        do_reset();
        rb = rise_t.size(); wb = width_bad; db = dir_hi_chg;
        rdb = rd_cnt; reb = rd_empty;
        foreach (scn_w[i]) push(scn_w[i]);
        at_pos(cyc + 1);
        t0 = cyc;
        en = 1'b1;
        model(t0);
        at_neg(exp_idle + 3);
        en = 1'b0;
        nobs = rise_t.size() - rb;
        chk({nm, " nrise"}, nobs, exp_rise.size());
        for (int i = 0; i < exp_rise.size() && i < nobs; i++) begin
            chk($sformatf("%s rise%0d_t", nm, i), rise_t[rb + i] - t0, exp_rise[i] - t0);
            chk($sformatf("%s rise%0d_dir", nm, i), int'(rise_d[rb + i]), int'(exp_dir[i]));
        end
        chk({nm, " width_err"}, width_bad - wb, 0);
        chk({nm, " dir_chg_hi"}, dir_hi_chg - db, 0);
        chk({nm, " pops"}, rd_cnt - rdb, scn_w.size());
        chk({nm, " rd_empty"}, rd_empty - reb, 0);
        chk({nm, " underrun"}, int'(underrun), exp_ur);
        chk({nm, " idle_t"}, last_fall - t0, exp_idle - t0);
        chk({nm, " busy"}, int'(busy), 0);
`ifdef STEP_POS_CNT_EN
        chk({nm, " pos"}, int'(pos), exp_pos);
`else
        chk({nm, " pos"}, int'(pos), 0);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, t1, rb, rdb, n;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst step", int'(step), 0);
        chk("rst dir", int'(dir), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst underrun", int'(underrun), 0);
        chk("rst pos", int'(pos), 0);
        chk("rst fifo_rd", int'(fifo_rd), 0);
        rst_n = 1'b1;

        scn_w = '{16'h0014};
        run_scn("t1_single");
        scn_w = '{16'h800A, 16'h800A, 16'h800A, 16'h8000};
        run_scn("t2_train");
        scn_w = '{16'h000A, 16'h800A};
        run_scn("t3_dirchg");
        scn_w = '{16'h0003, 16'h0003};
        run_scn("t4_clamp");
        scn_w = '{16'h0000, 16'h8009, 16'h0000, 16'h0005};
        run_scn("stop_mix");

        for (int s = 0; s < 10; s++) begin
            scn_w.delete();
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                logic [15:0] w;
                w[15]   = 1'($urandom_range(0, 1));
                w[14:0] = ($urandom_range(0, 6) == 0) ? 15'd0 : 15'($urandom_range(1, 24));
                scn_w.push_back(w);
            end
            run_scn($sformatf("rnd%0d", s));
        end

        // en dropped mid-pulse, then sticky underrun with set/clear coinciding
        do_reset();
        rb = rise_t.size(); rdb = rd_cnt;
        push(16'h000A);
        push(16'h000A);
        at_pos(cyc + 1);
        t0 = cyc;
        en = 1'b1;
        at_pos(t0 + 4);
        en = 1'b0;
        at_neg(t0 + 16);
        chk("t5 pops", rd_cnt - rdb, 1);
        chk("t5 left", wr_ptr - rd_ptr, 1);
        chk("t5 busy", int'(busy), 0);
        chk("t5 underrun", int'(underrun), 0);
        chk("t5 nrise", rise_t.size() - rb, 1);
        at_pos(cyc + 1);
        t1 = cyc;
        en = 1'b1;
        clr_underrun = 1'b1;
        at_neg(t1 + 13);
        chk("t5 rise2_t", rise_t[rise_t.size() - 1] - t1, 3);
        chk("t5 ur_set_wins", int'(underrun), 1);
        at_neg(t1 + 14);
        chk("t5 ur_cleared", int'(underrun), 0);
        clr_underrun = 1'b0;
        en = 1'b0;

        // Reset mid-HIGH
        do_reset();
        push(16'h000A);
        push(16'h000A);
        push(16'h000A);
        at_pos(cyc + 1);
        t0 = cyc;
        en = 1'b1;
        at_pos(t0 + 4);
        chk("t6 step_pre", int'(step), 1);
        rst_n = 1'b0;
        #1;
        chk("t6 step_async", int'(step), 0);
        chk("t6 busy_rst", int'(busy), 0);
        chk("t6 rd_in_rst", int'(fifo_rd), 0);
        rdb = rd_cnt;
        at_pos(cyc + 2);
        en = 1'b0;
        rst_n = 1'b1;
        at_neg(cyc + 6);
        chk("t6 busy", int'(busy), 0);
        chk("t6 step", int'(step), 0);
        chk("t6 dir", int'(dir), 0);
        chk("t6 pos", int'(pos), 0);
        chk("t6 underrun", int'(underrun), 0);
        chk("t6 no_rd", rd_cnt - rdb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
